// File: rtl/rom_arbiter.sv
// Two-requester round-robin burst reader in front of a combinational ROM.
// ROM_ARBITER_RANGE_CHECK_EN adds start-address checking, err_a/err_b and wrap at DEPTH.
module rom_arbiter #(
    parameter int DEPTH = 100,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [3:0]    len_a,
    input  logic [3:0]    len_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic          rlast_a,
    output logic          rlast_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
`ifdef ROM_ARBITER_RANGE_CHECK_EN
    output logic          err_a,
    output logic          err_b,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

`ifdef ROM_ARBITER_RANGE_CHECK_EN
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [4:0]    rem_q, rem_d;
    logic          owner_q, owner_d;
    logic          prefer_b_q, prefer_b_d;
    logic          rvalid_a_q, rvalid_a_d;
    logic          rvalid_b_q, rvalid_b_d;
    logic          rlast_a_q, rlast_a_d;
    logic          rlast_b_q, rlast_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d;
    logic [DW-1:0] rdata_b_q, rdata_b_d;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
    logic          err_a_q, err_a_d;
    logic          err_b_q, err_b_d;
`endif

    logic          any_req;
    logic          win_b;
    logic          take;
    logic          issue;
    logic          start_bad;
    logic [AW-1:0] start_addr;
    logic [3:0]    start_len;
    logic [4:0]    start_rem;
    logic [AW-1:0] addr_inc;

    // A previous grant to A hands priority to B and vice versa.
    always_comb begin
        any_req    = req_a | req_b;
        win_b      = req_b & (~req_a | prefer_b_q);
        take       = (state_q == IDLE) & any_req;
        issue      = (state_q == BURST);
        start_addr = win_b ? addr_b : addr_a;
        start_len  = win_b ? len_b : len_a;
        start_rem  = (start_len == 4'd0) ? 5'd16 : {1'b0, start_len};
`ifdef ROM_ARBITER_RANGE_CHECK_EN
        start_bad  = ({1'b0, start_addr} >= DEPTH_W);
        addr_inc   = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
`else
        start_bad  = 1'b0;
        addr_inc   = addr_q + AW'(1);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = start_bad ? DRAIN : BURST;
                end
            end
            BURST: begin
                if (rem_q == 5'd1) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        owner_d    = owner_q;
        prefer_b_d = prefer_b_q;
        if (take) begin
            addr_d     = start_addr;
            rem_d      = start_rem;
            owner_d    = win_b;
            prefer_b_d = ~win_b;
        end else if (issue) begin
            addr_d = addr_inc;
            rem_d  = rem_q - 5'd1;
        end
        rvalid_a_d = issue & ~owner_q;
        rvalid_b_d = issue & owner_q;
        rlast_a_d  = rvalid_a_d & (rem_q == 5'd1);
        rlast_b_d  = rvalid_b_d & (rem_q == 5'd1);
        rdata_a_d  = rvalid_a_d ? rom_data : rdata_a_q;
        rdata_b_d  = rvalid_b_d ? rom_data : rdata_b_q;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
        err_a_d    = take & ~win_b & start_bad;
        err_b_d    = take & win_b & start_bad;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            rem_q      <= '0;
            owner_q    <= 1'b0;
            prefer_b_q <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rlast_a_q  <= 1'b0;
            rlast_b_q  <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
`endif
        end else begin
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            owner_q    <= owner_d;
            prefer_b_q <= prefer_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rlast_a_q  <= rlast_a_d;
            rlast_b_q  <= rlast_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
`endif
        end
    end

    // Grants are combinational in IDLE, so mask them while reset is held.
    always_comb begin
        gnt_a    = take & ~win_b & reset;
        gnt_b    = take & win_b & reset;
        rom_rd   = issue;
        rom_addr = issue ? addr_q : '0;
        busy     = (state_q != IDLE);
        rvalid_a = rvalid_a_q;
        rvalid_b = rvalid_b_q;
        rlast_a  = rlast_a_q;
        rlast_b  = rlast_b_q;
        rdata_a  = rdata_a_q;
        rdata_b  = rdata_b_q;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
        err_a    = err_a_q;
        err_b    = err_b_q;
`endif
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: timeline reference model plus directed and random scenarios.
// Follows ROM_ARBITER_RANGE_CHECK_EN to match the design build.
module tb_rom_arbiter;

    localparam int DEPTH = 100;
    localparam int AW    = 8;
    localparam int DW    = 32;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
    localparam int OW = 10 + AW + 2*DW;
`else
    localparam int OW = 8 + AW + 2*DW;
`endif

    logic          clk;
    logic          reset;
    logic          req_a, req_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [3:0]    len_a, len_b;
    logic          gnt_a, gnt_b;
    logic          rvalid_a, rvalid_b;
    logic          rlast_a, rlast_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
    logic          err_a, err_b;
`endif

    logic [DW-1:0] rom_mem [256];
    assign rom_data = rom_mem[rom_addr];

    rom_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_a    (req_a),
        .req_b    (req_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .len_a    (len_a),
        .len_b    (len_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .rvalid_a (rvalid_a),
        .rvalid_b (rvalid_b),
        .rlast_a  (rlast_a),
        .rlast_b  (rlast_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
`ifdef ROM_ARBITER_RANGE_CHECK_EN
        .err_a    (err_a),
        .err_b    (err_b),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cyc;

    // Reference model: each grant books its reads and returns on a cycle timeline.
    int            free_at;
    int            busy_last;
    bit            prefer_b;
    int            rd_at   [int];
    bit            rv_own  [int];
    bit            rv_last [int];
    logic [DW-1:0] rv_data [int];
    logic          e_gnt_a, e_gnt_b, e_busy, e_rd;
    logic [AW-1:0] e_addr;
    logic          e_rv_a, e_rv_b, e_rl_a, e_rl_b;
    logic [DW-1:0] e_rd_a, e_rd_b;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
    bit            err_own [int];
    logic          e_err_a, e_err_b;
`endif

    function automatic logic [OW-1:0] obs();
        return {gnt_a, gnt_b, busy, rom_rd, rom_addr,
                rvalid_a, rvalid_b, rlast_a, rlast_b, rdata_a, rdata_b
`ifdef ROM_ARBITER_RANGE_CHECK_EN
                , err_a, err_b
`endif
               };
    endfunction

    function automatic logic [OW-1:0] expv();
        return {e_gnt_a, e_gnt_b, e_busy, e_rd, e_addr,
                e_rv_a, e_rv_b, e_rl_a, e_rl_b, e_rd_a, e_rd_b
`ifdef ROM_ARBITER_RANGE_CHECK_EN
                , e_err_a, e_err_b
`endif
               };
    endfunction

    task automatic model_reset();
        rd_at.delete();
        rv_own.delete();
        rv_last.delete();
        rv_data.delete();
        free_at   = cyc;
        busy_last = -1;
        prefer_b  = 1'b0;
        e_rd_a    = '0;
        e_rd_b    = '0;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
        err_own.delete();
`endif
    endtask

    task automatic model_step();
        bit wb;
        bit bad;
        int s;
        int l;
        int a;
        e_busy  = (cyc <= busy_last);
        e_gnt_a = 1'b0;
        e_gnt_b = 1'b0;
        if (cyc >= free_at && (req_a || req_b)) begin
            wb       = req_b && (!req_a || prefer_b);
            prefer_b = !wb;
            e_gnt_a  = !wb;
            e_gnt_b  = wb;
            s = wb ? int'(addr_b) : int'(addr_a);
            l = wb ? int'(len_b) : int'(len_a);
            if (l == 0) l = 16;
            bad = 1'b0;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
            bad = (s >= DEPTH);
            if (bad) begin
                err_own[cyc+1] = wb;
                free_at        = cyc + 2;
                busy_last      = cyc + 1;
            end
`endif
            if (!bad) begin
                for (int i = 0; i < l; i++) begin
`ifdef ROM_ARBITER_RANGE_CHECK_EN
                    a = (s + i) % DEPTH;
`else
                    a = (s + i) % (1 << AW);
`endif
                    rd_at[cyc+1+i]   = a;
                    rv_own[cyc+2+i]  = wb;
                    rv_last[cyc+2+i] = (i == l - 1);
                    rv_data[cyc+2+i] = rom_mem[a];
                end
                free_at   = cyc + l + 2;
                busy_last = cyc + l + 1;
            end
        end
        e_rd   = rd_at.exists(cyc);
        e_addr = e_rd ? AW'(rd_at[cyc]) : '0;
        e_rv_a = 1'b0;
        e_rv_b = 1'b0;
        e_rl_a = 1'b0;
        e_rl_b = 1'b0;
        if (rv_own.exists(cyc)) begin
            if (!rv_own[cyc]) begin
                e_rv_a = 1'b1;
                e_rl_a = rv_last[cyc];
                e_rd_a = rv_data[cyc];
            end else begin
                e_rv_b = 1'b1;
                e_rl_b = rv_last[cyc];
                e_rd_b = rv_data[cyc];
            end
        end
`ifdef ROM_ARBITER_RANGE_CHECK_EN
        e_err_a = err_own.exists(cyc) && !err_own[cyc];
        e_err_b = err_own.exists(cyc) && err_own[cyc];
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        addr_a = 8'd3;
        addr_b = 8'd7;
        len_a = 4'd2;
        len_b = 4'd2;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", obs());
        end
        @(negedge clk);
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL reset_held got=%h exp=0", obs());
        end
        do_reset();
    endtask

    task automatic test_single_a();
        logic [DW-1:0] got[$];
        bit ok;
        do_reset();
        req_a = 1'b1;
        addr_a = 8'd0;
        len_a = 4'd4;
        for (int k = 0; k < 8; k++) begin
            model_step();
            @(negedge clk);
            if (rvalid_a) got.push_back(rdata_a);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL single_a cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            tick();
            if (e_gnt_a) req_a = 1'b0;
        end
        ok = (got.size() == 4);
        for (int i = 0; i < got.size() && ok; i++) begin
            if (got[i] !== DW'(i + 1)) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_a_words got_count=%0d exp_count=4 (words 1..4)", got.size());
        end
    endtask

    task automatic test_contested();
        int ga;
        int gb;
        ga = -100;
        gb = -100;
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        addr_a = 8'd5;
        addr_b = 8'd40;
        len_a = 4'd2;
        len_b = 4'd2;
        for (int k = 0; k < 10; k++) begin
            model_step();
            @(negedge clk);
            if (gnt_a && ga < 0) ga = cyc;
            if (gnt_b && gb < 0) gb = cyc;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL contested cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            tick();
            if (e_gnt_a) req_a = 1'b0;
            if (e_gnt_b) req_b = 1'b0;
        end
        checks++;
        if (ga < 0 || gb - ga != 4) begin
            failures++;
            $display("FAIL contested_gap got=%0d exp=4", gb - ga);
        end
    endtask

    task automatic test_len16();
        int nrd;
        nrd = 0;
        do_reset();
        req_b = 1'b1;
        addr_b = 8'd10;
        len_b = 4'd0;
        for (int k = 0; k < 21; k++) begin
            model_step();
            @(negedge clk);
            if (rom_rd) nrd++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL len16 cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            tick();
            if (e_gnt_b) req_b = 1'b0;
        end
        checks++;
        if (nrd != 16) begin
            failures++;
            $display("FAIL len16_reads got=%0d exp=16", nrd);
        end
    endtask

    task automatic test_wrap();
        int nrd;
        nrd = 0;
        do_reset();
        req_a = 1'b1;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
        addr_a = 8'd98;
`else
        addr_a = 8'd254;
`endif
        len_a = 4'd4;
        for (int k = 0; k < 8; k++) begin
            model_step();
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            tick();
            if (e_gnt_a) req_a = 1'b0;
        end
`ifdef ROM_ARBITER_RANGE_CHECK_EN
        req_a = 1'b1;
        addr_a = 8'd120;
        len_a = 4'd3;
        for (int k = 0; k < 5; k++) begin
            model_step();
            @(negedge clk);
            if (rom_rd) nrd++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL range_err cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            tick();
            if (e_gnt_a) req_a = 1'b0;
        end
`endif
        checks++;
        if (nrd != 0) begin
            failures++;
            $display("FAIL range_no_read got=%0d exp=0", nrd);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a = 1'b1;
        addr_a = 8'd20;
        len_a = 4'd8;
        for (int k = 0; k < 3; k++) begin
            model_step();
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            tick();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL reset_mid_async got=%h exp=0", obs());
        end
        req_a = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 12; k++) begin
            model_step();
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int ga;
        int gb;
        int nbusy;
        ga = -100;
        gb = -100;
        nbusy = 0;
        do_reset();
        req_a = 1'b1;
        addr_a = 8'd50;
        len_a = 4'd3;
        for (int k = 0; k < 10; k++) begin
            model_step();
            @(negedge clk);
            if (gnt_a && ga < 0) ga = cyc;
            if (gnt_b && gb < 0) gb = cyc;
            if (ga >= 0 && cyc > ga && cyc <= ga + 4 && busy) nbusy++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            tick();
            if (e_gnt_a) req_a = 1'b0;
            if (e_gnt_b) req_b = 1'b0;
            if (k == 0) begin
                req_b = 1'b1;
                addr_b = 8'd60;
                len_b = 4'd2;
            end
        end
        checks++;
        if (ga < 0 || gb - ga != 5 || nbusy != 4) begin
            failures++;
            $display("FAIL back_to_back_gap got_gap=%0d exp_gap=5 got_busy=%0d exp_busy=4",
                     gb - ga, nbusy);
        end
    endtask

    task automatic test_random();
        int nrv;
        nrv = 0;
        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            model_step();
            @(negedge clk);
            if (rvalid_a || rvalid_b) nrv++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), expv());
            end
            tick();
            if (e_gnt_a) req_a = 1'b0;
            if (e_gnt_b) req_b = 1'b0;
            if (!req_a && $urandom_range(0, 2) == 0) begin
                req_a = 1'b1;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
                addr_a = AW'($urandom_range(0, 127));
`else
                addr_a = AW'($urandom_range(0, 255));
`endif
                len_a = 4'($urandom_range(0, 15));
            end
            if (!req_b && $urandom_range(0, 2) == 0) begin
                req_b = 1'b1;
`ifdef ROM_ARBITER_RANGE_CHECK_EN
                addr_b = AW'($urandom_range(0, 127));
`else
                addr_b = AW'($urandom_range(0, 255));
`endif
                len_b = 4'($urandom_range(0, 15));
            end
        end
        checks++;
        if (nrv == 0) begin
            failures++;
            $display("FAIL random_activity got=0 exp=nonzero");
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        req_a = 1'b0;
        req_b = 1'b0;
        addr_a = '0;
        addr_b = '0;
        len_a = '0;
        len_b = '0;
        for (int i = 0; i < 256; i++) rom_mem[i] = DW'(i + 1);
        model_reset();
        test_reset();
        test_single_a();
        test_contested();
        test_len16();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
